// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  // ID/EX control fields that a bubble forces low
  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic mem_write;
    logic b;
    logic s;
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW comparator between the ID instruction and older in-flight writers.
module hazard_detect #(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_use_src1,
  input  logic       id_use_src2,
  input  logic [3:0] ex_dest,
  input  logic       ex_wb_en,
  input  logic       ex_mem_read,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       hz
);

  localparam bit NO_FWD = !FORWARD_EN;

  logic match1;
  logic match2;

  // With forwarding only a load in EX is a hazard; without it any EX/MEM writer is
  assign match1 = (ex_wb_en & (ex_mem_read | NO_FWD) & (id_src1 == ex_dest)) |
                  (NO_FWD & mem_wb_en & (id_src1 == mem_dest));
  assign match2 = (ex_wb_en & (ex_mem_read | NO_FWD) & (id_src2 == ex_dest)) |
                  (NO_FWD & mem_wb_en & (id_src2 == mem_dest));

  assign hz = (id_use_src1 & match1) | (id_use_src2 & match2);

endmodule

// File: rtl/hazard_ctrl.sv
// Freeze/flush sequencing for the 5-stage core: RAW bubbles, branch flushes,
// data-memory wait with timeout, and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit FORWARD_EN  = 1'b1,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             id_src1,
  input  logic [3:0]             id_src2,
  input  logic                   id_use_src1,
  input  logic                   id_use_src2,
  input  logic [3:0]             ex_dest,
  input  logic                   ex_wb_en,
  input  logic                   ex_mem_read,
  input  logic [3:0]             mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   ex_branch,
  input  logic                   mem_req,
  input  logic                   sram_ready,
  input  logic                   cnt_clr,
  output logic                   freeze_pc,
  output logic                   freeze_ifid,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   freeze_back,
  output logic                   sram_req,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count,
  output state_t                 state_dbg
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_V = WW'(MEM_TIMEOUT);

  // Handshake: sram_req stays high until the cycle sram_ready is seen
  // (access complete) or the wait counter expires (access abandoned).

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic          err_set;
  logic          hz;

  hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_detect (
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src1 (id_use_src1),
    .id_use_src2 (id_use_src2),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_read (ex_mem_read),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .hz          (hz)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      mem_err  <= mem_err | err_set;
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    err_set     = 1'b0;
    freeze_pc   = 1'b0;
    freeze_ifid = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    freeze_back = 1'b0;
    sram_req    = 1'b0;
    // Outputs are held low for as long as reset is asserted
    if (rst) begin
      case (state)
        RUN: begin
          sram_req = mem_req;
          if (mem_req && !sram_ready) begin
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
            freeze_back = 1'b1;
            state_next  = MEM_WAIT;
            wait_next   = WW'(1);
          end else if (ex_branch) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (hz) begin
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
            flush_idex  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (sram_ready) begin
            sram_req   = 1'b1;
            state_next = RUN;
          end else if (wait_cnt == TIMEOUT_V) begin
            err_set    = 1'b1;
            state_next = RUN;
          end else begin
            sram_req    = 1'b1;
            freeze_pc   = 1'b1;
            freeze_ifid = 1'b1;
            freeze_back = 1'b1;
            wait_next   = wait_cnt + 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (freeze_pc && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush_idex && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding instance and one non-forwarding instance.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
  logic       id_use_src1, id_use_src2, ex_wb_en, ex_mem_read, mem_wb_en;
  logic       ex_branch, mem_req, sram_ready, cnt_clr;

  logic        f_freeze_pc, f_freeze_ifid, f_flush_ifid, f_flush_idex, f_freeze_back, f_sram_req, f_mem_err;
  logic [31:0] f_stall;
  logic [15:0] f_flush;
  state_t      f_state;
  logic        n_freeze_pc, n_freeze_ifid, n_flush_ifid, n_flush_idex, n_freeze_back, n_sram_req, n_mem_err;
  logic [31:0] n_stall;
  logic [15:0] n_flush;
  state_t      n_state;

  // {freeze_pc, freeze_ifid, flush_ifid, flush_idex, freeze_back, sram_req}
  logic [5:0] ctl_f, ctl_n;
  assign ctl_f = {f_freeze_pc, f_freeze_ifid, f_flush_ifid, f_flush_idex, f_freeze_back, f_sram_req};
  assign ctl_n = {n_freeze_pc, n_freeze_ifid, n_flush_ifid, n_flush_idex, n_freeze_back, n_sram_req};

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_HZ   = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001100;
  localparam logic [5:0] C_MEMF = 6'b110011;
  localparam logic [5:0] C_REQ  = 6'b000001;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARD_EN(1'b1), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .ex_branch(ex_branch), .mem_req(mem_req),
    .sram_ready(sram_ready), .cnt_clr(cnt_clr), .freeze_pc(f_freeze_pc),
    .freeze_ifid(f_freeze_ifid), .flush_ifid(f_flush_ifid), .flush_idex(f_flush_idex),
    .freeze_back(f_freeze_back), .sram_req(f_sram_req), .mem_err(f_mem_err),
    .stall_cycles(f_stall), .flush_count(f_flush), .state_dbg(f_state)
  );

  hazard_ctrl #(.FORWARD_EN(1'b0), .MEM_TIMEOUT(8)) dut_nf (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .ex_dest(ex_dest),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .ex_branch(ex_branch), .mem_req(mem_req),
    .sram_ready(sram_ready), .cnt_clr(cnt_clr), .freeze_pc(n_freeze_pc),
    .freeze_ifid(n_freeze_ifid), .flush_ifid(n_flush_ifid), .flush_idex(n_flush_idex),
    .freeze_back(n_freeze_back), .sram_req(n_sram_req), .mem_err(n_mem_err),
    .stall_cycles(n_stall), .flush_count(n_flush), .state_dbg(n_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    ex_dest = 4'd0; ex_wb_en = 1'b0; ex_mem_read = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; ex_branch = 1'b0;
    mem_req = 1'b0; sram_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic clr_counters();
    idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic set_load_use();
    ex_dest = 4'd3; ex_wb_en = 1'b1; ex_mem_read = 1'b1;
    id_src1 = 4'd3; id_use_src1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    mem_req = 1'b1; ex_branch = 1'b1;
    #3;
    n_checks++; if (ctl_f !== C_IDLE) begin n_errors++; $display("FAIL reset_ctl got %b want %b", ctl_f, C_IDLE); end
    n_checks++; if (f_state !== RUN) begin n_errors++; $display("FAIL reset_state got %0d want %0d", f_state, RUN); end
    n_checks++; if ({f_stall, f_flush, f_mem_err} !== 49'd0) begin n_errors++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0", f_stall, f_flush, f_mem_err); end
    idle();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    clr_counters();
    set_load_use();
    @(negedge clk);
    n_checks++; if (ctl_f !== C_HZ) begin n_errors++; $display("FAIL load_use_bubble got %b want %b", ctl_f, C_HZ); end
    step();
    ex_mem_read = 1'b0; ex_dest = 4'd7; mem_dest = 4'd3; mem_wb_en = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_IDLE) begin n_errors++; $display("FAIL load_use_release got %b want %b", ctl_f, C_IDLE); end
    n_checks++; if (ctl_n !== C_HZ) begin n_errors++; $display("FAIL nofwd_mem_match got %b want %b", ctl_n, C_HZ); end
    step();
    idle();
    @(negedge clk);
    n_checks++; if (f_stall !== 32'd1) begin n_errors++; $display("FAIL load_use_stall_cnt got %0d want 1", f_stall); end
    n_checks++; if (f_flush !== 16'd1) begin n_errors++; $display("FAIL load_use_flush_cnt got %0d want 1", f_flush); end
    step();
  endtask

  task automatic test_no_forward();
    idle();
    mem_dest = 4'd2; mem_wb_en = 1'b1; id_src1 = 4'd2; id_use_src1 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_n !== C_HZ) begin n_errors++; $display("FAIL nofwd_src1 got %b want %b", ctl_n, C_HZ); end
    n_checks++; if (ctl_f !== C_IDLE) begin n_errors++; $display("FAIL fwd_mem_ignored got %b want %b", ctl_f, C_IDLE); end
    step();
    id_use_src1 = 1'b0; id_src2 = 4'd2; id_use_src2 = 1'b0;
    @(negedge clk);
    n_checks++; if (ctl_n !== C_IDLE) begin n_errors++; $display("FAIL nofwd_src2_unused got %b want %b", ctl_n, C_IDLE); end
    step();
    id_use_src2 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_n !== C_HZ) begin n_errors++; $display("FAIL nofwd_src2 got %b want %b", ctl_n, C_HZ); end
    step();
    mem_wb_en = 1'b0;
    @(negedge clk);
    n_checks++; if (ctl_n !== C_IDLE) begin n_errors++; $display("FAIL nofwd_no_wb got %b want %b", ctl_n, C_IDLE); end
    step();
    idle();
    ex_dest = 4'd9; ex_wb_en = 1'b1; id_src2 = 4'd9; id_use_src2 = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_n !== C_HZ) begin n_errors++; $display("FAIL nofwd_ex_alu got %b want %b", ctl_n, C_HZ); end
    n_checks++; if (ctl_f !== C_IDLE) begin n_errors++; $display("FAIL fwd_ex_alu got %b want %b", ctl_f, C_IDLE); end
    step();
  endtask

  task automatic test_branch();
    clr_counters();
    set_load_use();
    ex_branch = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_BR) begin n_errors++; $display("FAIL branch_beats_hz got %b want %b", ctl_f, C_BR); end
    step();
    idle();
    @(negedge clk);
    n_checks++; if ({f_stall, f_flush} !== {32'd0, 16'd1}) begin n_errors++; $display("FAIL branch_cnt got %0d/%0d want 0/1", f_stall, f_flush); end
    step();
  endtask

  task automatic test_mem_wait();
    clr_counters();
    mem_req = 1'b1; ex_branch = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_MEMF) begin n_errors++; $display("FAIL mem_req_cycle got %b want %b", ctl_f, C_MEMF); end
    step();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++; if ({ctl_f, f_state} !== {C_MEMF, MEM_WAIT}) begin n_errors++; $display("FAIL mem_wait_%0d got %b/%0d want %b/%0d", k, ctl_f, f_state, C_MEMF, MEM_WAIT); end
      step();
    end
    sram_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_REQ) begin n_errors++; $display("FAIL mem_release got %b want %b", ctl_f, C_REQ); end
    step();
    mem_req = 1'b0; sram_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({ctl_f, f_state} !== {C_BR, RUN}) begin n_errors++; $display("FAIL held_branch got %b/%0d want %b/%0d", ctl_f, f_state, C_BR, RUN); end
    step();
    idle();
    @(negedge clk);
    n_checks++; if ({f_stall, f_flush} !== {32'd4, 16'd1}) begin n_errors++; $display("FAIL mem_wait_cnt got %0d/%0d want 4/1", f_stall, f_flush); end
    step();
  endtask

  task automatic test_back_to_back();
    clr_counters();
    mem_req = 1'b1; sram_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_REQ) begin n_errors++; $display("FAIL single_cycle got %b want %b", ctl_f, C_REQ); end
    step();
    sram_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({ctl_f, f_state} !== {C_MEMF, RUN}) begin n_errors++; $display("FAIL b2b_first got %b/%0d want %b/%0d", ctl_f, f_state, C_MEMF, RUN); end
    step();
    sram_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({ctl_f, f_state} !== {C_REQ, MEM_WAIT}) begin n_errors++; $display("FAIL b2b_release got %b/%0d want %b/%0d", ctl_f, f_state, C_REQ, MEM_WAIT); end
    step();
    sram_ready = 1'b0;
    @(negedge clk);
    n_checks++; if ({ctl_f, f_state} !== {C_MEMF, RUN}) begin n_errors++; $display("FAIL b2b_second got %b/%0d want %b/%0d", ctl_f, f_state, C_MEMF, RUN); end
    step();
    sram_ready = 1'b1;
    step();
    idle();
    @(negedge clk);
    n_checks++; if ({f_stall, f_state} !== {32'd2, RUN}) begin n_errors++; $display("FAIL b2b_end got %0d/%0d want 2/%0d", f_stall, f_state, RUN); end
    step();
  endtask

  task automatic test_timeout();
    clr_counters();
    mem_req = 1'b1;
    @(negedge clk);
    n_checks++; if (ctl_f !== C_MEMF) begin n_errors++; $display("FAIL to_req got %b want %b", ctl_f, C_MEMF); end
    step();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_checks++; if ({ctl_f, f_mem_err} !== {C_MEMF, 1'b0}) begin n_errors++; $display("FAIL to_wait_%0d got %b/%b want %b/0", k, ctl_f, f_mem_err, C_MEMF); end
      step();
    end
    @(negedge clk);
    n_checks++; if ({ctl_f, f_state, f_mem_err} !== {C_IDLE, MEM_WAIT, 1'b0}) begin n_errors++; $display("FAIL to_expire got %b/%0d/%b want %b/%0d/0", ctl_f, f_state, f_mem_err, C_IDLE, MEM_WAIT); end
    step();
    mem_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({f_mem_err, f_state, ctl_f} !== {1'b1, RUN, C_IDLE}) begin n_errors++; $display("FAIL to_err got %b/%0d/%b want 1/%0d/%b", f_mem_err, f_state, ctl_f, RUN, C_IDLE); end
    n_checks++; if (f_stall !== 32'd8) begin n_errors++; $display("FAIL to_stall_cnt got %0d want 8", f_stall); end
    step();
    clr_counters();
    @(negedge clk);
    n_checks++; if (f_mem_err !== 1'b1) begin n_errors++; $display("FAIL to_sticky got %b want 1", f_mem_err); end
    step();
  endtask

  task automatic test_reset_mid_access();
    idle();
    mem_req = 1'b1;
    step();
    step();
    n_checks++; if (f_state !== MEM_WAIT) begin n_errors++; $display("FAIL rst_pre_state got %0d want %0d", f_state, MEM_WAIT); end
    rst = 1'b0;
    #1;
    n_checks++; if ({ctl_f, f_state} !== {C_IDLE, RUN}) begin n_errors++; $display("FAIL rst_async got %b/%0d want %b/%0d", ctl_f, f_state, C_IDLE, RUN); end
    n_checks++; if ({f_mem_err, f_stall} !== 33'd0) begin n_errors++; $display("FAIL rst_regs got %b/%0d want 0/0", f_mem_err, f_stall); end
    idle();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    clr_counters();
    ex_branch = 1'b1;
    repeat (65540) step();
    @(negedge clk);
    n_checks++; if ({f_flush, f_stall} !== {16'hFFFF, 32'd0}) begin n_errors++; $display("FAIL sat_flush got %h/%0d want ffff/0", f_flush, f_stall); end
    step();
    ex_branch = 1'b0;
    set_load_use();
    step();
    @(negedge clk);
    n_checks++; if ({f_flush, f_stall} !== {16'hFFFF, 32'd1}) begin n_errors++; $display("FAIL sat_hold got %h/%0d want ffff/1", f_flush, f_stall); end
    step();
    cnt_clr = 1'b1;
    step();
    idle();
    @(negedge clk);
    n_checks++; if ({f_flush, f_stall} !== 48'd0) begin n_errors++; $display("FAIL cnt_clr got %h/%0d want 0/0", f_flush, f_stall); end
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_forward();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
